// File: rtl/intfsm_ctrl.sv
// -----------------------------------------------------------------------------
// intfsm_ctrl
//
// Interconnect control FSM. During INIT it latches and validates the ten FIFO
// almost-full / almost-empty thresholds and drives them, registered, into the
// Main, VC0, VC1, D0 and D1 FIFOs. At run time it watches the FIFO empty and
// error flags and reports idle / active / sticky-error status.
//
// Ports
//   clk                      : clock, rising edge
//   reset_L                  : asynchronous reset, active low
//   init                     : request to enter/stay in INIT and load thresholds
//   Umbral*_in               : candidate thresholds (LEN4 or LEN16 wide)
//   *_empty, *_error_output  : FIFO status flags
//   Umbral*                  : registered thresholds to the interconnect
//   state                    : current state code
//   idle_out/active_out/
//   error_out                : state indicators decoded from the state register
//   cfg_error                : last sampled threshold set was invalid
// -----------------------------------------------------------------------------
module intfsm_ctrl #(
  parameter int LEN4  = 4,
  parameter int LEN16 = 16
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [LEN4-1:0]  UmbralMF_HIGH_in,
  input  logic [LEN4-1:0]  UmbralMF_LOW_in,
  input  logic [LEN4-1:0]  UmbralD0_HIGH_in,
  input  logic [LEN4-1:0]  UmbralD0_LOW_in,
  input  logic [LEN4-1:0]  UmbralD1_HIGH_in,
  input  logic [LEN4-1:0]  UmbralD1_LOW_in,
  input  logic [LEN16-1:0] UmbralV0_HIGH_in,
  input  logic [LEN16-1:0] UmbralV0_LOW_in,
  input  logic [LEN16-1:0] UmbralV1_HIGH_in,
  input  logic [LEN16-1:0] UmbralV1_LOW_in,
  input  logic             Main_empty,
  input  logic             VC0_empty,
  input  logic             VC1_empty,
  input  logic             D0_empty,
  input  logic             D1_empty,
  input  logic             Main_error_output,
  input  logic             VC0_error_output,
  input  logic             VC1_error_output,
  input  logic             D0_error_output,
  input  logic             D1_error_output,
  output logic [LEN4-1:0]  UmbralMF_HIGH,
  output logic [LEN4-1:0]  UmbralMF_LOW,
  output logic [LEN4-1:0]  UmbralD0_HIGH,
  output logic [LEN4-1:0]  UmbralD0_LOW,
  output logic [LEN4-1:0]  UmbralD1_HIGH,
  output logic [LEN4-1:0]  UmbralD1_LOW,
  output logic [LEN16-1:0] UmbralV0_HIGH,
  output logic [LEN16-1:0] UmbralV0_LOW,
  output logic [LEN16-1:0] UmbralV1_HIGH,
  output logic [LEN16-1:0] UmbralV1_LOW,
  output logic [2:0]       state,
  output logic             idle_out,
  output logic             active_out,
  output logic             error_out,
  output logic             cfg_error
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  logic [2:0] state_q, state_d;

  logic [LEN4-1:0]  mf_hi_q, mf_lo_q, d0_hi_q, d0_lo_q, d1_hi_q, d1_lo_q;
  logic [LEN16-1:0] v0_hi_q, v0_lo_q, v1_hi_q, v1_lo_q;
  logic             cfg_error_q;

  logic err_any;
  logic all_empty;
  logic cfg_ok;
  logic load;

  assign err_any   = Main_error_output | VC0_error_output | VC1_error_output |
                     D0_error_output   | D1_error_output;
  assign all_empty = Main_empty & VC0_empty & VC1_empty & D0_empty & D1_empty;

  // Validity is judged on the candidate values, so a corrected set can leave
  // INIT on the same edge that latches it.
  assign cfg_ok = (UmbralMF_LOW_in <= UmbralMF_HIGH_in) &
                  (UmbralD0_LOW_in <= UmbralD0_HIGH_in) &
                  (UmbralD1_LOW_in <= UmbralD1_HIGH_in) &
                  (UmbralV0_LOW_in <= UmbralV0_HIGH_in) &
                  (UmbralV1_LOW_in <= UmbralV1_HIGH_in);

  assign load = (state_q == ST_INIT);

  always_comb begin
    state_d = ST_RESET;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (err_any)              state_d = ST_ERROR;
        else if (!init && cfg_ok) state_d = ST_IDLE;
        else                      state_d = ST_INIT;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (err_any)        state_d = ST_ERROR;
        else if (init)      state_d = ST_INIT;
        else if (all_empty) state_d = ST_IDLE;
        else                state_d = ST_ACTIVE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;  // illegal codes recover through RESET
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mf_hi_q     <= '0;
      mf_lo_q     <= '0;
      d0_hi_q     <= '0;
      d0_lo_q     <= '0;
      d1_hi_q     <= '0;
      d1_lo_q     <= '0;
      v0_hi_q     <= '0;
      v0_lo_q     <= '0;
      v1_hi_q     <= '0;
      v1_lo_q     <= '0;
      cfg_error_q <= 1'b0;
    end else if (load) begin
      mf_hi_q     <= UmbralMF_HIGH_in;
      mf_lo_q     <= UmbralMF_LOW_in;
      d0_hi_q     <= UmbralD0_HIGH_in;
      d0_lo_q     <= UmbralD0_LOW_in;
      d1_hi_q     <= UmbralD1_HIGH_in;
      d1_lo_q     <= UmbralD1_LOW_in;
      v0_hi_q     <= UmbralV0_HIGH_in;
      v0_lo_q     <= UmbralV0_LOW_in;
      v1_hi_q     <= UmbralV1_HIGH_in;
      v1_lo_q     <= UmbralV1_LOW_in;
      cfg_error_q <= ~cfg_ok;
    end
  end

  assign UmbralMF_HIGH = mf_hi_q;
  assign UmbralMF_LOW  = mf_lo_q;
  assign UmbralD0_HIGH = d0_hi_q;
  assign UmbralD0_LOW  = d0_lo_q;
  assign UmbralD1_HIGH = d1_hi_q;
  assign UmbralD1_LOW  = d1_lo_q;
  assign UmbralV0_HIGH = v0_hi_q;
  assign UmbralV0_LOW  = v0_lo_q;
  assign UmbralV1_HIGH = v1_hi_q;
  assign UmbralV1_LOW  = v1_lo_q;
  assign cfg_error     = cfg_error_q;

  assign state      = state_q;
  assign idle_out   = (state_q == ST_IDLE);
  assign active_out = (state_q == ST_ACTIVE);
  assign error_out  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_intfsm_ctrl.sv
module tb_intfsm_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_L;
  logic        init;
  // Threshold index map: 0 MF_H, 1 MF_L, 2 D0_H, 3 D0_L, 4 D1_H, 5 D1_L,
  // 6 V0_H, 7 V0_L, 8 V1_H, 9 V1_L. LOW always sits at HIGH's index + 1.
  logic [3:0]  in4 [6];
  logic [15:0] in16[4];
  logic [3:0]  out4 [6];
  logic [15:0] out16[4];
  // bit order: 0 Main, 1 VC0, 2 VC1, 3 D0, 4 D1
  logic [4:0]  empt;
  logic [4:0]  errs;
  logic [2:0]  state;
  logic        idle_out, active_out, error_out, cfg_error;

  intfsm_ctrl #(.LEN4(4), .LEN16(16)) dut (
    .clk               (clk),
    .reset_L           (reset_L),
    .init              (init),
    .UmbralMF_HIGH_in  (in4[0]),
    .UmbralMF_LOW_in   (in4[1]),
    .UmbralD0_HIGH_in  (in4[2]),
    .UmbralD0_LOW_in   (in4[3]),
    .UmbralD1_HIGH_in  (in4[4]),
    .UmbralD1_LOW_in   (in4[5]),
    .UmbralV0_HIGH_in  (in16[0]),
    .UmbralV0_LOW_in   (in16[1]),
    .UmbralV1_HIGH_in  (in16[2]),
    .UmbralV1_LOW_in   (in16[3]),
    .Main_empty        (empt[0]),
    .VC0_empty         (empt[1]),
    .VC1_empty         (empt[2]),
    .D0_empty          (empt[3]),
    .D1_empty          (empt[4]),
    .Main_error_output (errs[0]),
    .VC0_error_output  (errs[1]),
    .VC1_error_output  (errs[2]),
    .D0_error_output   (errs[3]),
    .D1_error_output   (errs[4]),
    .UmbralMF_HIGH     (out4[0]),
    .UmbralMF_LOW      (out4[1]),
    .UmbralD0_HIGH     (out4[2]),
    .UmbralD0_LOW      (out4[3]),
    .UmbralD1_HIGH     (out4[4]),
    .UmbralD1_LOW      (out4[5]),
    .UmbralV0_HIGH     (out16[0]),
    .UmbralV0_LOW      (out16[1]),
    .UmbralV1_HIGH     (out16[2]),
    .UmbralV1_LOW      (out16[3]),
    .state             (state),
    .idle_out          (idle_out),
    .active_out        (active_out),
    .error_out         (error_out),
    .cfg_error         (cfg_error)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: state kept as the documented integer code.
  int          m_state;
  int unsigned m_thr[10];
  bit          m_cfg_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned in_val(input int i);
    return (i < 6) ? int'(in4[i]) : int'(in16[i-6]);
  endfunction

  function automatic int unsigned out_val(input int i);
    return (i < 6) ? int'(out4[i]) : int'(out16[i-6]);
  endfunction

  function automatic bit cfg_ok_now();
    bit ok = 1'b1;
    for (int k = 0; k < 5; k++)
      if (in_val(2*k+1) > in_val(2*k)) ok = 1'b0;
    return ok;
  endfunction

  task automatic check_all(input string pfx);
    check({pfx, ".state"},  32'(state),      32'(m_state));
    check({pfx, ".idle"},   32'(idle_out),   32'(m_state == 2));
    check({pfx, ".active"}, 32'(active_out), 32'(m_state == 3));
    check({pfx, ".error"},  32'(error_out),  32'(m_state == 4));
    check({pfx, ".cfgerr"}, 32'(cfg_error),  32'(m_cfg_err));
    for (int i = 0; i < 10; i++)
      check($sformatf("%s.thr%0d", pfx, i), out_val(i), m_thr[i]);
  endtask

  // One clock: predict from the inputs seen at the edge, then compare after it.
  task automatic step(input string pfx);
    int n_state;
    bit err_any  = |errs;
    bit all_emp  = &empt;
    bit ok       = cfg_ok_now();
    case (m_state)
      0: n_state = 1;
      1: n_state = err_any ? 4 : ((!init && ok) ? 2 : 1);
      2, 3: begin
        if (err_any)      n_state = 4;
        else if (init)    n_state = 1;
        else if (all_emp) n_state = 2;
        else              n_state = 3;
      end
      4: n_state = 4;
      default: n_state = 0;
    endcase
    if (m_state == 1) begin
      for (int i = 0; i < 10; i++) m_thr[i] = in_val(i);
      m_cfg_err = !ok;
    end
    @(posedge clk);
    #1;
    m_state = n_state;
    check_all(pfx);
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_cfg_err = 1'b0;
    for (int i = 0; i < 10; i++) m_thr[i] = 0;
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(input string pfx);
    reset_L = 1'b0;
    #1;
    model_reset();
    check_all(pfx);
    reset_L = 1'b1;
  endtask

  task automatic set_cfg(input logic [3:0] mfh, input logic [3:0] mfl,
                         input logic [3:0] d0h, input logic [3:0] d0l,
                         input logic [3:0] d1h, input logic [3:0] d1l,
                         input logic [15:0] vh, input logic [15:0] vl);
    in4[0] = mfh; in4[1] = mfl; in4[2] = d0h; in4[3] = d0l;
    in4[4] = d1h; in4[5] = d1l;
    in16[0] = vh; in16[1] = vl; in16[2] = vh; in16[3] = vl;
  endtask

  initial begin
    reset_L = 1'b0;
    init    = 1'b0;
    empt    = '1;
    errs    = '0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_all("por");

    // Bring-up: init for 3 cycles after the RESET->INIT edge, then to IDLE.
    #10;
    set_cfg(12, 2, 3, 1, 3, 1, 40, 4);
    init = 1'b1;
    reset_L = 1'b1;
    step("bring0");
    for (int i = 0; i < 3; i++) step("bring_init");
    init = 1'b0;
    step("bring_idle");

    // Traffic on VC0 for 4 cycles.
    empt[1] = 1'b0;
    for (int i = 0; i < 4; i++) step("vc0_busy");
    empt[1] = 1'b1;
    step("vc0_done");

    // Invalid D1 pair holds INIT with cfg_error; correcting it exits.
    init = 1'b1;
    step("reinit");
    set_cfg(12, 2, 3, 1, 2, 5, 40, 4);
    init = 1'b0;
    step("badcfg0");
    step("badcfg1");
    in4[5] = 4'd1;
    step("fixcfg");

    // Error in ACTIVE is sticky, init ignored; async reset clears it.
    empt[3] = 1'b0;
    step("to_active");
    errs[3] = 1'b1;
    step("d0_err");
    errs[3] = 1'b0;
    init = 1'b1;
    for (int i = 0; i < 10; i++) step("err_sticky");
    async_reset("rst_from_err");

    // init + error together in ACTIVE -> ERROR.
    step("r1_a");
    step("r1_b");
    init = 1'b0;
    step("r1_idle");
    step("r1_active");
    init = 1'b1;
    errs[0] = 1'b1;
    step("init_and_err");
    errs[0] = 1'b0;
    init = 1'b0;
    async_reset("rst2");

    // init alone in ACTIVE -> INIT and the new thresholds reload.
    empt = '1;
    step("r2_a");
    step("r2_b");
    step("r2_idle");
    empt[4] = 1'b0;
    step("r2_active");
    set_cfg(9, 9, 15, 0, 7, 6, 16'hBEEF, 16'h0123);
    init = 1'b1;
    step("active_to_init");
    step("reload");
    init = 1'b0;
    empt = '1;
    step("reload_idle");

    // Illegal state code recovers through RESET.
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    m_state = 6;
    check_all("illegal");
    step("illegal_rec0");
    step("illegal_rec1");

    // Randomized run against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 39) == 0) async_reset("rnd_rst");
      init = ($urandom_range(0, 5) == 0);
      for (int b = 0; b < 5; b++) empt[b] = ($urandom_range(0, 3) != 0);
      errs = '0;
      if ($urandom_range(0, 29) == 0) errs[$urandom_range(0, 4)] = 1'b1;
      for (int i = 0; i < 6; i++) in4[i] = 4'($urandom);
      for (int i = 0; i < 4; i++) in16[i] = 16'($urandom);
      // Bias toward valid sets so IDLE/ACTIVE get exercised.
      if ($urandom_range(0, 2) != 0) begin
        for (int k = 0; k < 3; k++) if (in4[2*k+1] > in4[2*k]) in4[2*k+1] = in4[2*k];
        for (int k = 0; k < 2; k++) if (in16[2*k+1] > in16[2*k]) in16[2*k+1] = in16[2*k];
      end
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intfsm_ctrl.md
# intfsm_ctrl

Control state machine that sits directly upstream of the interconnect's FIFO threshold (Umbral) inputs. It latches and validates the ten almost-full/almost-empty thresholds during initialization and drives them, registered, into the Main, VC0, VC1, D0 and D1 FIFOs. At run time it watches the five FIFO empty and error flags and reports whether the interconnect is idle, active or in a sticky error state.

## Interface

Parameters:

- LEN4, 4: width of the Main, D0 and D1 thresholds.
- LEN16, 16: width of the VC0 and VC1 thresholds.

Ports:

- clk, input, 1: single clock; all state changes on the rising edge.
- reset_L, input, 1: reset is asynchronous and active-low.
- init, input, 1: request to enter or stay in INIT and load thresholds.
- UmbralMF_HIGH_in, UmbralMF_LOW_in, UmbralD0_HIGH_in, UmbralD0_LOW_in, UmbralD1_HIGH_in, UmbralD1_LOW_in, input, LEN4 each: candidate thresholds.
- UmbralV0_HIGH_in, UmbralV0_LOW_in, UmbralV1_HIGH_in, UmbralV1_LOW_in, input, LEN16 each: candidate thresholds.
- Main_empty, VC0_empty, VC1_empty, D0_empty, D1_empty, input, 1 each: FIFO empty flags.
- Main_error_output, VC0_error_output, VC1_error_output, D0_error_output, D1_error_output, input, 1 each: FIFO error flags.
- UmbralMF_HIGH, UmbralMF_LOW, UmbralD0_HIGH, UmbralD0_LOW, UmbralD1_HIGH, UmbralD1_LOW, output, LEN4 each: registered thresholds to the interconnect.
- UmbralV0_HIGH, UmbralV0_LOW, UmbralV1_HIGH, UmbralV1_LOW, output, LEN16 each: registered thresholds to the interconnect.
- state, output, 3: current state code.
- idle_out, active_out, error_out, output, 1 each: state indicators.
- cfg_error, output, 1: latched threshold set is invalid.

## Operation

- States and codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Codes 5–7 are illegal and go to RESET on the next clock.
- Definitions:
  - err_any = OR of the five *_error_output inputs.
  - all_empty = AND of the five *_empty inputs.
  - cfg_ok = every LOW ≤ its HIGH, checked on the *_in values using unsigned compare.
- Transitions are evaluated in priority order; the first matching row wins.
  - RESET: go to INIT.
  - INIT:
    - err_any → ERROR.
    - Else, !init && cfg_ok → IDLE.
    - Else, stay in INIT.
  - IDLE and ACTIVE:
    - err_any → ERROR.
    - Else, init → INIT.
    - Else, all_empty → IDLE.
    - Else → ACTIVE.
  - ERROR: sticky. Only reset_L=0 leaves it; init is ignored.
- Threshold registers load from the *_in values on every clock edge where the current state is INIT. They hold their value in all other states.
- cfg_error is registered. On each edge where the current state is INIT it is set to !cfg_ok; it holds in all other states. It therefore shows the validity of the last sampled set.
- Outputs are Moore-style, decoded from the state register:
  - idle_out = (state==IDLE).
  - active_out = (state==ACTIVE).
  - error_out = (state==ERROR).

## Timing

- Asynchronous reset values:
  - state = RESET.
  - All Umbral outputs = 0.
  - cfg_error = 0.
  - idle_out, active_out and error_out = 0.
- After reset_L rises, the first edge moves RESET→INIT; the second edge samples the *_in values.
- Threshold latency: the *_in values sampled at edge N appear on the outputs after edge N, i.e. they are valid in cycle N+1.
- Flag latency:
  - The cycle after an error or empty input changes, state and the indicators reflect it.
  - The inputs are not re-registered internally.
- Simultaneous events:
  - err_any together with init → ERROR.
  - init together with all_empty in ACTIVE → INIT.
- Invalid configuration: when init=0 and cfg_ok=0, the block stays in INIT with cfg_error=1. It exits to IDLE on the first edge where cfg_ok=1; that same edge latches the valid values and clears cfg_error.
- Reset mid-operation from any state: state and outputs return to their reset values immediately, with no clock required.

## Test plan

- Reset, then init=1 for 3 cycles with MF=(H 12, L 2), V0/V1=(H 40, L 4), D0/D1=(H 3, L 1), then init=0 with all FIFOs empty → state sequence 0,1,1,1,2. Outputs equal the inputs from the cycle after the first INIT edge.
- From IDLE, VC0_empty=0 for 4 cycles, then 1 → state goes 3 for 4 cycles, then back to 2. active_out mirrors this; the thresholds do not change.
- In INIT, drive D1 LOW=5, HIGH=2 and deassert init → the block stays in state 1 with cfg_error=1. Correcting D1 LOW to 1 → state 2 next edge and cfg_error=0.
- In ACTIVE, pulse D0_error_output for 1 cycle → state 4 and error_out=1. Error persists with init=1 for 10 cycles; after reset_L=0, state is 0 and all outputs are 0 asynchronously.
- In ACTIVE, assert init and Main_error_output on the same cycle → state 4. Separately, init alone with D1_empty=0 → state 1, and the thresholds reload.
- Force the state register to 6 (illegal code) → state 0 on the next edge, then 1.
